// File: rtl/ysyx_23060201_gpr_pkg.sv
// Shared types and constants for the scoreboarded GPR file.
// Optional read forwarding is enabled by defining GPR_BYPASS_EN.
package ysyx_23060201_gpr_pkg;

   typedef enum logic {
      GPR_CLEAR = 1'b0,
      GPR_READY = 1'b1
   } gpr_state_e;

   localparam int GPR_ZERO_IDX = 0;

   function automatic int gpr_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/ysyx_23060201_gpr_rdport.sv
// One read port: enable gating, x0 forcing, clear-phase forcing and,
// with GPR_BYPASS_EN defined, forwarding of the same-cycle write-back.
module ysyx_23060201_gpr_rdport
   import ysyx_23060201_gpr_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clearing,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] arr_data,
   input  logic                  arr_busy,
`ifdef GPR_BYPASS_EN
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  lock_en,
   input  logic [ADDR_WIDTH-1:0] lock_addr,
`endif
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_busy
);

   logic                  fwd_hit;
   logic                  fwd_busy;
   logic [DATA_WIDTH-1:0] fwd_data;

`ifdef GPR_BYPASS_EN
   // A lock in the same cycle marks a newer producer, so the forwarded value is already stale.
   assign fwd_hit  = wr_en && (wr_addr == rd_addr);
   assign fwd_busy = lock_en && (lock_addr == rd_addr);
   assign fwd_data = wr_data;
`else
   assign fwd_hit  = 1'b0;
   assign fwd_busy = 1'b0;
   assign fwd_data = '0;
`endif

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      rd_data = '0;
      rd_busy = 1'b0;
      if (clearing) begin
         rd_busy = 1'b1;
      end else if (rd_en && (rd_addr != ADDR_WIDTH'(GPR_ZERO_IDX))) begin
         if (fwd_hit) begin
            rd_data = fwd_data;
            rd_busy = fwd_busy;
         end else begin
            rd_data = arr_data;
            rd_busy = arr_busy;
         end
      end
   end

endmodule

// File: rtl/ysyx_23060201_gpr_sb.sv
// Parametrised GPR file with NUM_RD read ports, busy-bit scoreboard and a
// post-reset clear engine. Define GPR_BYPASS_EN for write-to-read forwarding.
module ysyx_23060201_gpr_sb
   import ysyx_23060201_gpr_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         ready,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic                         wr_en,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         lock_en,
   input  logic [ADDR_WIDTH-1:0]        lock_addr
);

   localparam int DEPTH = gpr_depth(ADDR_WIDTH);

   gpr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      busy_q;

   logic                  clearing;
   logic                  wr_live;
   logic                  lock_live;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   assign clearing  = (state_q == GPR_CLEAR);
   assign ready     = (state_q == GPR_READY);
   assign wr_live   = ready && wr_en && (wr_addr != ADDR_WIDTH'(GPR_ZERO_IDX));
   assign lock_live = ready && lock_en && (lock_addr != ADDR_WIDTH'(GPR_ZERO_IDX));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= GPR_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == GPR_CLEAR) begin
         clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
         if (&clr_cnt_q) state_d = GPR_READY;
      end
   end

   // The clear engine and write-back share the single array write port.
   always_comb begin
      mem_we    = rst_n && (clearing || wr_live);
      mem_waddr = clearing ? clr_cnt_q : wr_addr;
      mem_wdata = clearing ? '0 : wr_data;
   end

   // NOTE: the array has no reset term; the clear engine zeroes it after reset instead.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         // NOTE: non-blocking, and the later lock assignment wins over the write-back clear.
         if (wr_live)   busy_q[wr_addr]   <= 1'b0;
         if (lock_live) busy_q[lock_addr] <= 1'b1;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

      ysyx_23060201_gpr_rdport #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_rdport (
         .clearing  (clearing),
         .rd_en     (rd_en[p]),
         .rd_addr   (addr),
         .arr_data  (mem[addr]),
         .arr_busy  (busy_q[addr]),
`ifdef GPR_BYPASS_EN
         .wr_en     (wr_en),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .lock_en   (lock_en),
         .lock_addr (lock_addr),
`endif
         .rd_data   (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
         .rd_busy   (rd_busy[p])
      );
   end

endmodule

// File: tb/tb_ysyx_23060201_gpr_sb.sv
// Directed self-checking bench for ysyx_23060201_gpr_sb (three read ports).
// Bypass expectations follow GPR_BYPASS_EN.
module tb_ysyx_23060201_gpr_sb;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ready;
   logic [NR-1:0]    rd_en;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_busy;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             lock_en;
   logic [AW-1:0]    lock_addr;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   ysyx_23060201_gpr_sb #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_RD     (NR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ready     (ready),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .lock_en   (lock_en),
      .lock_addr (lock_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      wr_en   = 1'b0;
      lock_en = 1'b0;
   endtask

   task automatic read_all(input logic [AW-1:0] a);
      rd_en   = '1;
      rd_addr = {NR{a}};
   endtask

   task automatic expect_rd(input string tag, input logic [DW-1:0] d, input logic [NR-1:0] b);
      #1;
      check({tag, "_data"}, rd_data, {NR{d}});
      check({tag, "_busy"}, rd_busy, b);
   endtask

   task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick;
      idle;
   endtask

   task automatic lock_reg(input logic [AW-1:0] a);
      lock_en = 1'b1; lock_addr = a;
      tick;
      idle;
   endtask

   task automatic count_to_ready(output int n);
      n = 0;
      while (!ready && n < 200) begin
         tick;
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; idle;
      rd_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0; lock_addr = '0;
      tick; tick;
      check("rst_ready", ready, 1'b0);
      read_all(5'd3);
      expect_rd("rst_clear", 32'h0, 3'b111);

      // Release reset; inject a write and lock during the clear that must be ignored.
      rst_n = 1'b1;
      cyc = 0;
      while (!ready && cyc < 200) begin
         if (cyc == 10) begin
            wr_en = 1'b1; wr_addr = 5'd4; wr_data = '1;
            lock_en = 1'b1; lock_addr = 5'd6;
         end else begin
            idle;
         end
         tick;
         cyc++;
      end
      idle;
      check("clr_latency", cyc, 32);

      for (int a = 0; a < 32; a++) begin
         read_all(a[AW-1:0]);
         expect_rd($sformatf("init_x%0d", a), 32'h0, 3'b000);
         tick;
      end

      // Mid-clear reset restarts the full clear.
      write_reg(5'd8, 32'h77);
      read_all(5'd8);
      expect_rd("pre_rst_x8", 32'h77, 3'b000);
      rst_n = 1'b0; tick; rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick;
      rst_n = 1'b0; tick; rst_n = 1'b1;
      check("midclr_ready", ready, 1'b0);
      count_to_ready(cyc);
      check("midclr_latency", cyc, 32);
      read_all(5'd8);
      expect_rd("post_rst_x8", 32'h0, 3'b000);

      lock_reg(5'd5);
      read_all(5'd5);
      expect_rd("lock_x5", 32'h0, 3'b111);
      write_reg(5'd5, 32'hDEADBEEF);
      read_all(5'd5);
      expect_rd("wb_x5", 32'hDEADBEEF, 3'b000);

      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
      lock_en = 1'b1; lock_addr = 5'd7;
      tick; idle;
      read_all(5'd7);
      expect_rd("lockwr_x7", 32'h1234, 3'b111);

      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
      lock_en = 1'b1; lock_addr = 5'd0;
      tick; idle;
      read_all(5'd0);
      expect_rd("x0", 32'h0, 3'b000);

      write_reg(5'd9, 32'hA5A5A5A5);
      read_all(5'd9);
      expect_rd("x9_all", 32'hA5A5A5A5, 3'b000);
      lock_reg(5'd9);
      rd_en = 3'b101;
      #1;
      check("x9_en101_data", rd_data, {32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5});
      check("x9_en101_busy", rd_busy, 3'b101);

      rd_en = '1;
      rd_addr = {5'd0, 5'd7, 5'd5};
      #1;
      check("mixed_data", rd_data, {32'h0, 32'h1234, 32'hDEADBEEF});
      check("mixed_busy", rd_busy, 3'b010);

      // Non-busy write keeps busy at 0; double lock needs only one write-back.
      write_reg(5'd10, 32'hAB);
      read_all(5'd10);
      expect_rd("x10_free", 32'hAB, 3'b000);
      lock_reg(5'd10);
      lock_reg(5'd10);
      read_all(5'd10);
      expect_rd("x10_dbl_lock", 32'hAB, 3'b111);
      write_reg(5'd10, 32'hCD);
      read_all(5'd10);
      expect_rd("x10_release", 32'hCD, 3'b000);

      // Read during write on the same index.
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
      lock_en = 1'b1; lock_addr = 5'd3;
      tick; idle;
      read_all(5'd3);
      expect_rd("x3_setup", 32'h11, 3'b111);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
`ifdef GPR_BYPASS_EN
      expect_rd("rdw_x3", 32'h55, 3'b000);
`else
      expect_rd("rdw_x3", 32'h11, 3'b111);
`endif
      tick; idle;
      expect_rd("x3_after", 32'h55, 3'b000);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
      lock_en = 1'b1; lock_addr = 5'd3;
`ifdef GPR_BYPASS_EN
      expect_rd("rdw_lock_x3", 32'h66, 3'b111);
`else
      expect_rd("rdw_lock_x3", 32'h55, 3'b000);
`endif
      tick; idle;
      expect_rd("x3_final", 32'h66, 3'b111);

      read_all(5'd6);
      expect_rd("x6_untouched", 32'h0, 3'b000);
      read_all(5'd4);
      expect_rd("x4_untouched", 32'h0, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
